// File: rtl/seq_verify_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_verify_pkg                                                  |
// | Purpose  : Shared constants and FSM state encoding for the verifier.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seq_verify_pkg;

  localparam int c_DIGITS      = 5;
  localparam int c_DIGIT_W     = 4;
  localparam int c_SEQ_W       = c_DIGITS * c_DIGIT_W;
  localparam int c_ADDR_W      = 5;
  localparam int c_SEQ_ADDR    = 0;
  localparam int c_TIMEOUT_CYC = 1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_timer                                                       |
// | Purpose  : Inactivity counter; saturates and flags expiry at TIMEOUT_CYC-1.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYC);

  logic [c_CNT_W-1:0] r_count;

  assign expire = (r_count == c_CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_verify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_verify                                                      |
// | Purpose  : Fetches the stored reference sequence and checks keypad entry.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_verify
  import seq_verify_pkg::*;
#(
  parameter int DIGITS      = c_DIGITS,
  parameter int DIGIT_W     = c_DIGIT_W,
  parameter int ADDR_W      = c_ADDR_W,
  parameter int SEQ_ADDR    = c_SEQ_ADDR,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      key_valid,
  input  logic [DIGIT_W-1:0]        key_digit,
  input  logic [DIGITS*DIGIT_W-1:0] RAM_data,
  output logic                      RAM_R,
  output logic [ADDR_W-1:0]         RAM_addr,
  output logic                      busy,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [2:0]                digit_count
);

  localparam int c_SEQ_W = DIGITS * DIGIT_W;

  state_t              r_state, w_state_n;
  logic [c_SEQ_W-1:0]  r_ref, w_ref_n;
  logic                r_err, w_err_n;
  logic [2:0]          r_cnt, w_cnt_n;
  logic                r_ram_r, w_ram_r_n;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_n;
  logic                r_busy, w_busy_n;
  logic                r_pass, w_pass_n;
  logic                r_fail, w_fail_n;
  logic                r_timeout, w_timeout_n;

  logic                w_expire;
  logic                w_tmr_clr;
  logic                w_tmr_en;
  logic [2:0]          w_sel;
  logic [c_SEQ_W-1:0]  w_ref_sh;
  logic [DIGIT_W-1:0]  w_ref_digit;
  logic                w_err_now;

  // Reference digit for the current position, MS digit first
  assign w_sel       = 3'(DIGITS - 1) - r_cnt;
  assign w_ref_sh    = r_ref >> (w_sel * DIGIT_W);
  assign w_ref_digit = w_ref_sh[DIGIT_W-1:0];
  assign w_err_now   = r_err | (key_digit != w_ref_digit);

  assign w_tmr_en  = (r_state == ST_COLLECT);
  assign w_tmr_clr = (r_state == ST_LOAD) || ((r_state == ST_COLLECT) && key_valid);

  seq_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_tmr_clr),
    .en     (w_tmr_en),
    .expire (w_expire)
  );

  always_comb begin
    w_state_n    = r_state;
    w_ref_n      = r_ref;
    w_err_n      = r_err;
    w_cnt_n      = r_cnt;
    w_ram_r_n    = 1'b0;
    w_ram_addr_n = r_ram_addr;
    w_busy_n     = r_busy;
    w_pass_n     = 1'b0;
    w_fail_n     = 1'b0;
    w_timeout_n  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n    = ST_FETCH;
          w_ram_r_n    = 1'b1;
          w_ram_addr_n = ADDR_W'(SEQ_ADDR);
          w_busy_n     = 1'b1;
        end
      end
      ST_FETCH: w_state_n = ST_LOAD;
      ST_LOAD: begin
        w_ref_n   = RAM_data;
        w_err_n   = 1'b0;
        w_cnt_n   = 3'd0;
        w_state_n = ST_COLLECT;
      end
      ST_COLLECT: begin
        // A key on the expiry cycle takes priority over the timeout
        if (key_valid) begin
          w_err_n = w_err_now;
          w_cnt_n = r_cnt + 3'd1;
          if (r_cnt == 3'(DIGITS - 1)) begin
            w_state_n = ST_RESULT;
            w_pass_n  = !w_err_now;
            w_fail_n  = w_err_now;
          end
        end else if (w_expire) begin
          w_state_n   = ST_RESULT;
          w_fail_n    = 1'b1;
          w_timeout_n = 1'b1;
        end
      end
      ST_RESULT: begin
        w_busy_n  = 1'b0;
        w_cnt_n   = 3'd0;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ref      <= '0;
      r_err      <= 1'b0;
      r_cnt      <= 3'd0;
      r_ram_r    <= 1'b0;
      r_ram_addr <= '0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ref      <= w_ref_n;
      r_err      <= w_err_n;
      r_cnt      <= w_cnt_n;
      r_ram_r    <= w_ram_r_n;
      r_ram_addr <= w_ram_addr_n;
      r_busy     <= w_busy_n;
      r_pass     <= w_pass_n;
      r_fail     <= w_fail_n;
      r_timeout  <= w_timeout_n;
    end
  end

  assign RAM_R       = r_ram_r;
  assign RAM_addr    = r_ram_addr;
  assign busy        = r_busy;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign digit_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_verify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_verify                                                   |
// | Purpose  : Self-checking bench: vector table, corner sequences, random.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_verify;

  localparam int c_TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic [19:0] RAM_data = 20'd0;
  logic        RAM_R;
  logic [4:0]  RAM_addr;
  logic        busy, pass, fail, timeout;
  logic [2:0]  digit_count;

  logic [19:0] mem [32];
  int          n_vec = 0;
  int          n_bad = 0;

  seq_verify #(.TIMEOUT_CYC(c_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
    .key_digit(key_digit), .RAM_data(RAM_data), .RAM_R(RAM_R),
    .RAM_addr(RAM_addr), .busy(busy), .pass(pass), .fail(fail),
    .timeout(timeout), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid the cycle after RAM_R
  always @(posedge clk) if (RAM_R) RAM_data <= mem[RAM_addr];

  typedef struct packed {
    logic [19:0] refv;
    logic [3:0]  n;
    logic [31:0] dig;   // key i digit in nibble i
    logic [63:0] off;   // key i cycle offset from start edge in byte i
    logic [7:0]  sa;    // extra start pulse offset, 0 = none
    logic        ep, ef, et;
    logic [2:0]  ec;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_attempt(input logic [19:0] refv, input int n, input logic [31:0] dig,
                             input logic [63:0] off, input int sa, input bit use_tab,
                             input bit ep, input bit ef, input bit et, input int ec);
    int acc, last, r_cyc, t, cnt;
    bit err, to, mp;
    int acc_t [8];
    acc = 0; last = 2; r_cyc = -1; err = 0; to = 0;
    for (int i = 0; i < 32; i++) mem[i] = ~refv;
    mem[0] = refv;
    // Reference: walk the keys in time order, applying the timeout window
    for (int i = 0; i < n; i++) begin
      t = int'(off[8*i +: 8]);
      if (t < 3) continue;
      if (t > last + c_TO) begin
        r_cyc = last + c_TO; to = 1; break;
      end
      if (dig[4*i +: 4] != refv[4*(4-acc) +: 4]) err = 1;
      acc_t[acc] = t;
      acc++;
      last = t;
      if (acc == 5) begin
        r_cyc = t; break;
      end
    end
    if (r_cyc < 0) begin
      r_cyc = last + c_TO; to = 1;
    end
    mp = !to && !err;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= r_cyc + 2; c++) begin
      cnt = 0;
      for (int j = 0; j < acc; j++) if (acc_t[j] <= c) cnt++;
      if (c > r_cyc) cnt = 0;
      chk("busy", int'(busy), int'(c <= r_cyc));
      chk("pass", int'(pass), int'(c == r_cyc && mp));
      chk("fail", int'(fail), int'(c == r_cyc && !mp));
      chk("timeout", int'(timeout), int'(c == r_cyc && to));
      chk("digit_count", int'(digit_count), cnt);
      chk("RAM_R", int'(RAM_R), int'(c == 0));
      if (c == 0) chk("RAM_addr", int'(RAM_addr), 0);
      if (use_tab && c == r_cyc) begin
        chk("tab_pass", int'(pass), int'(ep));
        chk("tab_fail", int'(fail), int'(ef));
        chk("tab_timeout", int'(timeout), int'(et));
        chk("tab_count", int'(digit_count), ec);
      end
      start = (c + 1 == sa) && (c + 1 <= r_cyc);
      key_valid = 1'b0;
      key_digit = 4'd0;
      for (int i = 0; i < n; i++) begin
        if (int'(off[8*i +: 8]) == c + 1) begin
          key_valid = 1'b1;
          key_digit = dig[4*i +: 4];
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    key_valid = 1'b0;
  endtask

  vec_t tab [9];

  initial begin
    tab[0] = '{20'h12345, 4'd5, 32'h00054321, 64'h00000007_06050403, 8'd0, 1'b1, 1'b0, 1'b0, 3'd5};
    tab[1] = '{20'h12345, 4'd5, 32'h00054921, 64'h0000000C_0A080604, 8'd0, 1'b0, 1'b1, 1'b0, 3'd5};
    tab[2] = '{20'h12345, 4'd2, 32'h00000021, 64'h00000000_00000503, 8'd0, 1'b0, 1'b1, 1'b1, 3'd2};
    tab[3] = '{20'h12345, 4'd6, 32'h00543217, 64'h00000706_05040302, 8'd5, 1'b1, 1'b0, 1'b0, 3'd5};
    tab[4] = '{20'h12345, 4'd5, 32'h00054321, 64'h00000016_15141303, 8'd0, 1'b1, 1'b0, 1'b0, 3'd5};
    tab[5] = '{20'h12345, 4'd5, 32'h00054321, 64'h00000016_15141312, 8'd0, 1'b1, 1'b0, 1'b0, 3'd5};
    tab[6] = '{20'h12345, 4'd1, 32'h00000001, 64'h00000000_00000013, 8'd0, 1'b0, 1'b1, 1'b1, 3'd0};
    tab[7] = '{20'h12345, 4'd5, 32'h00064321, 64'h00000008_07060504, 8'd0, 1'b0, 1'b1, 1'b0, 3'd5};
    tab[8] = '{20'hABCDE, 4'd5, 32'h000EDCBA, 64'h00000007_06050403, 8'd6, 1'b1, 1'b0, 1'b0, 3'd5};

    for (int i = 0; i < 32; i++) mem[i] = 20'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_RAM_R", int'(RAM_R), 0);
    chk("rst_count", int'(digit_count), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++)
      run_attempt(tab[v].refv, int'(tab[v].n), tab[v].dig, tab[v].off, int'(tab[v].sa),
                  1'b1, tab[v].ep, tab[v].ef, tab[v].et, int'(tab[v].ec));

    // Reset mid-attempt after three accepted keys
    mem[0] = 20'h12345;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      key_valid = (c + 1 >= 3) && (c + 1 <= 5);
      key_digit = 4'(c - 1);
    end
    key_valid = 1'b0;
    chk("pre_rst_count", int'(digit_count), 3);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(digit_count), 0);
    chk("async_rst_pass", int'(pass | fail | timeout | RAM_R), 0);
    @(negedge clk);
    rst = 1'b0;
    run_attempt(20'h12345, 5, 32'h00054321, 64'h00000007_06050403, 0, 1'b1, 1'b1, 1'b0, 1'b0, 5);

    // Randomised attempts against the reference
    for (int a = 0; a < 40; a++) begin
      logic [19:0] rv;
      logic [31:0] dg;
      logic [63:0] of;
      int n, t, skipped, idx, sa;
      rv = 20'($urandom);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 8);
      dg = '0; of = '0; skipped = 0;
      t = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if (i > 0)
          t += ($urandom_range(0, 9) == 0) ? $urandom_range(14, 19) : $urandom_range(1, 4);
        of[8*i +: 8] = 8'(t);
        if (t < 3) skipped++;
        idx = i - skipped;
        if (idx > 4) idx = 4;
        if (idx < 0) idx = 0;
        dg[4*i +: 4] = ($urandom_range(0, 3) != 0) ? rv[4*(4-idx) +: 4] : 4'($urandom);
      end
      sa = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30);
      run_attempt(rv, n, dg, of, sa, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
